// File: rtl/alu_pipe_pkg.sv
// ============================================================================
// Module   : alu_pipe_pkg
// Summary  : Op-code encodings, FSM state type and decode helper for alu_pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pipe_pkg;

    // Group select, alu_code[4:3]
    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_SET   = 2'b11;

    // Arithmetic sub-ops (1xx passes a)
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;

    // Logic sub-ops
    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOTA  = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_NOR   = 3'b101;
    localparam logic [2:0] OP_XNOR  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Shift sub-ops (101..111 pass a)
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Set-condition sub-ops
    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LTS = 3'b010;
    localparam logic [2:0] OP_LES = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_LEU = 3'b101;
    localparam logic [2:0] OP_GTS = 3'b110;
    localparam logic [2:0] OP_GES = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // True for the five real shift/rotate ops; the pass-a codes stay single-cycle.
    function automatic logic is_iter_shift(input logic [4:0] code);
        return (code[4:3] == GRP_SHIFT) && (code[2:0] <= OP_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_pipe_comb.sv
// ============================================================================
// Module   : alu_pipe_comb
// Summary  : Single-cycle result path: arith, logic, set-condition, pass/n=0 shift.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_pipe_comb
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_code,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int              MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [1:0]       w_grp;
    logic [2:0]       w_sub;
    logic [WIDTH-1:0] w_opnd;
    logic             w_is_sub;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_arith;
    logic             w_sovf;
    logic             w_eq;
    logic             w_lts;
    logic             w_ltu;
    logic             w_cond;

    assign w_grp = alu_code[4:3];
    assign w_sub = alu_code[2:0];
    assign w_eq  = (a == b);
    assign w_lts = ($signed(a) < $signed(b));
    assign w_ltu = (a < b);

    // Bit WIDTH of the extended sum is the carry for add and the borrow for sub.
    always_comb begin
        w_opnd   = ((w_sub == OP_ADD) || (w_sub == OP_SUB)) ? b : C_ONE;
        w_is_sub = (w_sub == OP_SUB) || (w_sub == OP_DEC);
        if (w_is_sub) begin
            w_ext = {1'b0, a} - {1'b0, w_opnd};
        end else begin
            w_ext = {1'b0, a} + {1'b0, w_opnd};
        end
        w_arith = w_ext[WIDTH-1:0];
        if (w_is_sub) begin
            w_sovf = (a[MSB] != w_opnd[MSB]) && (w_arith[MSB] != a[MSB]);
        end else begin
            w_sovf = (a[MSB] == w_opnd[MSB]) && (w_arith[MSB] != a[MSB]);
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (w_sub)
            OP_EQ:   w_cond = w_eq;
            OP_NE:   w_cond = !w_eq;
            OP_LTS:  w_cond = w_lts;
            OP_LES:  w_cond = w_lts || w_eq;
            OP_LTU:  w_cond = w_ltu;
            OP_LEU:  w_cond = w_ltu || w_eq;
            OP_GTS:  w_cond = !(w_lts || w_eq);
            OP_GES:  w_cond = !w_lts;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (w_grp)
            GRP_ARITH: begin
                if (w_sub[2]) begin
                    result = a;
                end else begin
                    result   = w_arith;
                    overflow = w_sovf | w_ext[WIDTH];
                end
            end
            GRP_LOGIC: begin
                case (w_sub)
                    OP_AND:   result = a & b;
                    OP_OR:    result = a | b;
                    OP_XOR:   result = a ^ b;
                    OP_NOTA:  result = ~a;
                    OP_NAND:  result = ~(a & b);
                    OP_NOR:   result = ~(a | b);
                    OP_XNOR:  result = ~(a ^ b);
                    default:  result = b;
                endcase
            end
            GRP_SHIFT: result = a;
            default:   result = {{(WIDTH-1){1'b0}}, w_cond};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Summary  : Handshaked ALU with iterative 1-bit/cycle shifter and registered
//            output. Define ALU_PIPE_STICKY_EN to add ovf_sticky/clr_sticky.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             overflow
`ifdef ALU_PIPE_STICKY_EN
    ,
    output logic             ovf_sticky,
    input  logic             clr_sticky
`endif
);

    localparam logic [SHW-1:0] C_CNT_ONE = SHW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       op_q, op_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_pop;
    logic             w_start_shift;
    logic             w_load;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_comb_c;
    logic             w_comb_ovf;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    alu_pipe_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a        (a),
        .b        (b),
        .alu_code (alu_code),
        .result   (w_comb_c),
        .overflow (w_comb_ovf)
    );

    assign w_amt         = b[SHW-1:0];
    assign w_start_shift = is_iter_shift(alu_code) && (w_amt != '0);
    assign w_accept      = in_valid & w_in_ready;
    assign w_pop         = out_valid_q & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept && w_start_shift) state_d = SHIFT;
            SHIFT:   if (count_q == C_CNT_ONE)      state_d = HOLD;
            HOLD:    if (w_pop) state_d = (w_accept && w_start_shift) ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: in_ready never looks at in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        case (state_q)
            IDLE:    w_in_ready = !out_valid_q | out_ready;
            HOLD:    w_in_ready = out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    // One-bit step of the working register; w_out_bit is what sll pushes out.
    always_comb begin
        w_shifted = work_q;
        w_out_bit = 1'b0;
        case (op_q)
            OP_SLL: begin
                w_shifted = {work_q[WIDTH-2:0], 1'b0};
                w_out_bit = work_q[WIDTH-1];
            end
            OP_SRL:  w_shifted = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  w_shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            OP_ROL:  w_shifted = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            OP_ROR:  w_shifted = {work_q[0], work_q[WIDTH-1:1]};
            default: w_shifted = work_q;
        endcase
    end

    always_comb begin
        work_d     = work_q;
        op_d       = op_q;
        count_d    = count_q;
        acc_ovf_d  = acc_ovf_q;
        c_d        = c_q;
        overflow_d = overflow_q;
        w_load     = 1'b0;

        if (w_accept) begin
            if (w_start_shift) begin
                work_d    = a;
                op_d      = alu_code[2:0];
                count_d   = w_amt;
                acc_ovf_d = 1'b0;
            end else begin
                c_d        = w_comb_c;
                overflow_d = w_comb_ovf;
                w_load     = 1'b1;
            end
        end

        // Accept is impossible in SHIFT, so this never competes with the load above.
        if (state_q == SHIFT) begin
            work_d    = w_shifted;
            count_d   = count_q - C_CNT_ONE;
            acc_ovf_d = acc_ovf_q | w_out_bit;
            if (count_q == C_CNT_ONE) begin
                c_d        = w_shifted;
                overflow_d = acc_ovf_q | w_out_bit;
                w_load     = 1'b1;
            end
        end

        out_valid_d = w_load | (out_valid_q & ~w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q      <= '0;
            op_q        <= '0;
            count_q     <= '0;
            acc_ovf_q   <= 1'b0;
            c_q         <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            work_q      <= work_d;
            op_q        <= op_d;
            count_q     <= count_d;
            acc_ovf_q   <= acc_ovf_d;
            c_q         <= c_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign overflow  = overflow_q;

`ifdef ALU_PIPE_STICKY_EN
    logic ovf_sticky_q, ovf_sticky_d;

    // Set has priority over clear.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (clr_sticky) ovf_sticky_d = 1'b0;
        if (w_load && overflow_d) ovf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit combinational ALU. Operands and a 5-bit op code enter through a valid/ready input port. Results leave through a single-entry registered output with valid/ready. Arithmetic, logic and set-condition ops complete in one cycle; shifts and rotates run on an iterative one-bit-per-cycle shifter, so a wide barrel shifter is not needed. The block sits between the datapath's operand-fetch stage and writeback.

## Interface
- WIDTH, 16: operand and result width; must be ≥ 4.
- SHW, $clog2(WIDTH): width of the shift-amount field taken from b.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- a, b  in  WIDTH  operands.
- alu_code  in  5  [4:3] selects the group (00 arith, 01 logic, 10 shift, 11 set); [2:0] selects the sub-op.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result.
- c  out  WIDTH  result.
- overflow  out  1  overflow of the held result.
- ovf_sticky  out  1  present only with ALU_PIPE_STICKY_EN; see Configuration.
- clr_sticky  in  1  present only with ALU_PIPE_STICKY_EN; see Configuration.

## Operation
- Arith: 000 a+b; 001 a−b; 010 a+1; 011 a−1; 1xx pass a.
  - overflow = signed overflow OR unsigned carry/borrow.
  - For pass a, overflow = 0.
- Logic: 000 and; 001 or; 010 xor; 011 ~a; 100 nand; 101 nor; 110 xnor; 111 pass b. overflow = 0.
- Shift, with amount n = b[SHW-1:0]: 000 sll; 001 srl; 010 sra; 011 rol; 100 ror; 1x1 and 110 pass a.
  - overflow = 0, except for sll, where it is 1 if any 1-bit is shifted out.
- Set: 000 eq; 001 ne; 010 lt signed; 011 le signed; 100 lt unsigned; 101 le unsigned; 110 gt signed; 111 ge signed.
  - c = {0…0, cond}; overflow = 0.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: in_ready = !out_valid | out_ready.
    - On accept of a non-shift op, or a shift op with n = 0, or a pass op: load c/overflow; stay in IDLE; out_valid = 1.
    - On accept of a shift op with n > 0: latch a, op and count = n; go to SHIFT; in_ready = 0.
  - SHIFT: in_ready = 0. Each cycle, shift the working register by 1 and decrement count.
    - When count reaches 1, the shifted value is written to c with out_valid = 1, and the state goes to HOLD.
  - HOLD: in_ready = out_ready. A handshake returns the state to IDLE; accepting in the same cycle follows the IDLE accept rules.
- Output register: out_valid clears on out_valid & out_ready, unless a new result loads in the same cycle; in that case out_valid stays 1 and c is replaced.
- Inputs are sampled only on in_valid & in_ready. a and b may change freely while the block is in SHIFT.
- Reset, including mid-shift: state = IDLE, out_valid = 0, c = 0, overflow = 0, count = 0, ovf_sticky = 0. Any in-flight op is discarded.

## Timing
- Non-shift and n = 0: accept at edge k → result valid after edge k; one accept per cycle is possible with out_ready held high.
- Shift with n > 0: accept at edge k → out_valid after edge k+n; in_ready is low for n cycles.
- No combinational path from in_valid to in_ready. in_ready depends on out_ready combinationally.

## Configuration
- ALU_PIPE_STICKY_EN defined:
  - The ports ovf_sticky and clr_sticky exist.
  - ovf_sticky is set when a result with overflow = 1 is loaded into the output register.
  - clr_sticky clears it. If clear and set happen in the same cycle, set wins.
  - ovf_sticky resets to 0.
- ALU_PIPE_STICKY_EN undefined: those ports and that register are absent; all other behaviour is identical.

## Structure
- Package alu_pipe_pkg holds:
  - the group encodings (GRP_ARITH, GRP_LOGIC, GRP_SHIFT, GRP_SET);
  - the sub-op constants;
  - the FSM state typedef (IDLE, SHIFT, HOLD).
- One sub-module, alu_pipe_comb: the purely combinational single-cycle groups (arith, logic, set, plus n = 0 and pass shifts), producing result and overflow.
- The FSM, the iterative shifter and the output register live in alu_pipe.

## Test plan
- WIDTH = 16, a = 0x7FFF, b = 0x0001, add, out_ready = 1 → c = 0x8000 and overflow = 1, one cycle after accept.
- Back-to-back logic ops xor(0xF0F0, 0xFF00), then and → c = 0x0FF0, then 0xF000, on consecutive cycles; in_ready stays 1.
- sra of a = 0x8004, n = 3 → in_ready low for 3 cycles; c = 0xF000 on cycle 3; overflow = 0. With sll of 0x8004, n = 3 → c = 0x0020, overflow = 1.
- Set-condition lt signed of 0xFFFF vs 0x0001 → c = 0x0001; lt unsigned of the same operands → c = 0x0000.
- out_ready low for 4 cycles after a result → c and out_valid stay held and in_ready stays 0; on release, the handshake and the next accept happen in the same cycle.
- rst asserted during the 2nd SHIFT cycle of a rol with n = 5 → out_valid = 0 and c = 0 immediately. After release the next op completes normally. With ALU_PIPE_STICKY_EN, ovf_sticky = 0 after reset and after clr_sticky.
